// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: owns HI/LO, models fixed latency with a counter FSM.
// Optional multiply-accumulate (md_op 9/10) is built only when MDU_MADD_EN is defined.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd9;
  localparam logic [3:0] OpMaddu = 4'd10;
`endif

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  // Operation decode
  logic is_mul, is_div, mul_signed, div_signed;
  assign is_div     = (md_op == OpDiv) || (md_op == OpDivu);
  assign div_signed = (md_op == OpDiv);
`ifdef MDU_MADD_EN
  logic is_acc;
  assign is_acc     = (md_op == OpMadd) || (md_op == OpMaddu);
  assign is_mul     = (md_op == OpMult) || (md_op == OpMultu) || is_acc;
  assign mul_signed = (md_op == OpMult) || (md_op == OpMadd);
`else
  assign is_mul     = (md_op == OpMult) || (md_op == OpMultu);
  assign mul_signed = (md_op == OpMult);
`endif

  // One 64x64 multiplier serves both signednesses; the low 64 bits are exact either way.
  logic [63:0] mul_a, mul_b, prod, mul_res;
  assign mul_a = {{32{mul_signed & rs_val[31]}}, rs_val};
  assign mul_b = {{32{mul_signed & rt_val[31]}}, rt_val};
  assign prod  = mul_a * mul_b;
`ifdef MDU_MADD_EN
  assign mul_res = is_acc ? (prod + {hi_q, lo_q}) : prod;
`else
  assign mul_res = prod;
`endif

  // Signed divide via magnitudes; 0x8000_0000 / -1 falls out as q=0x8000_0000, r=0.
  logic        neg_a, neg_b;
  logic [31:0] div_a, div_b, quo_mag, rem_mag, div_q, div_r;
  assign neg_a   = div_signed & rs_val[31];
  assign neg_b   = div_signed & rt_val[31];
  assign div_a   = neg_a ? (~rs_val + 32'd1) : rs_val;
  assign div_b   = neg_b ? (~rt_val + 32'd1) : rt_val;
  assign quo_mag = (div_b == 32'd0) ? 32'd0 : (div_a / div_b);
  assign rem_mag = (div_b == 32'd0) ? 32'd0 : (div_a % div_b);

  always_comb begin
    div_q = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
    div_r = neg_a ? (~rem_mag + 32'd1) : rem_mag;
    if (rt_val == 32'd0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = rs_val;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mul) begin
            {sh_hi_d, sh_lo_d} = mul_res;
            count_d = MultCnt;
            busy_d  = 1'b1;
            state_d = StRun;
          end else if (is_div) begin
            sh_hi_d = div_r;
            sh_lo_d = div_q;
            count_d = DivCnt;
            busy_d  = 1'b1;
            state_d = StRun;
          end else if (md_op == OpMthi) begin
            hi_d = rs_val;
          end else if (md_op == OpMtlo) begin
            lo_d = rs_val;
          end
        end
      end
      StRun: begin
        // start is ignored here; the hazard unit never issues while busy
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdu_out = (md_op == OpMfhi) ? hi_q : ((md_op == OpMflo) ? lo_q : 32'd0);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized bench for mdu_ctrl against a plain-arithmetic HI/LO model, plus directed corner cases.
module tb_mdu_ctrl;

  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;
  localparam logic [3:0] OpMaddu = 4'd10;

  logic        clk, reset, start, busy;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val, hi, lo, mdu_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .mdu_out(mdu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result {hi,lo} and busy latency for one issued instruction.
  function automatic void model(input logic st, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                                output logic [63:0] res, output int lat);
    int     ia, ib, q, r;
    longint sa, sb;
    ia  = a;
    ib  = b;
    sa  = ia;
    sb  = ib;
    res = {h, l};
    lat = 0;
    if (st) begin
      case (op)
        OpMult:  begin res = sa * sb; lat = MultCycles; end
        OpMultu: begin res = {32'd0, a} * {32'd0, b}; lat = MultCycles; end
        OpDiv: begin
          lat = DivCycles;
          if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
          else begin
            q   = ia / ib;
            r   = ia % ib;
            res = {r, q};
          end
        end
        OpDivu: begin
          lat = DivCycles;
          if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
          else res = {a % b, a / b};
        end
        OpMthi: res = {a, l};
        OpMtlo: res = {h, a};
`ifdef MDU_MADD_EN
        4'd9:    begin res = {h, l} + 64'(sa * sb); lat = MultCycles; end
        OpMaddu: begin res = {h, l} + {32'd0, a} * {32'd0, b}; lat = MultCycles; end
`endif
        default: ;
      endcase
    end
  endfunction

  task automatic run_op(input logic st, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp;
    int          lat;
    model(st, op, a, b, m_hi, m_lo, exp, lat);
    @(negedge clk);
    start = st; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = OpNone; rs_val = $urandom; rt_val = $urandom;
    for (int i = 1; i <= lat; i++) begin
      check("busy_run", {63'd0, busy}, 64'd1);
      check("hilo_hold", {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
    end
    check("busy_done", {63'd0, busy}, 64'd0);
    check("hilo_commit", {hi, lo}, exp);
    {m_hi, m_lo} = exp;
    md_op = OpMfhi;
    #1 check("mfhi", {32'd0, mdu_out}, {32'd0, m_hi});
    md_op = OpMflo;
    #1 check("mflo", {32'd0, mdu_out}, {32'd0, m_lo});
    md_op = OpNone;
    #1 check("mf_none", {32'd0, mdu_out}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] exp;
    int          lat;
    reset = 1'b0; start = 1'b0; md_op = OpNone; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    md_op = OpMflo;
    #1 check("rst_mflo", {32'd0, mdu_out}, 64'd0);
    md_op = OpNone;
    @(negedge clk);
    reset = 1'b1;

    run_op(1'b1, OpMult, 32'hFFFF_FFFE, 32'd3);
    check("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op(1'b1, OpMultu, 32'hFFFF_FFFE, 32'd3);
    check("multu_const", {hi, lo}, {32'd2, 32'hFFFF_FFFA});
    run_op(1'b1, OpDiv, 32'hFFFF_FFF9, 32'd2);
    check("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(1'b1, OpDivu, 32'd7, 32'd0);
    check("divu_zero", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
    run_op(1'b1, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(1'b1, OpMthi, 32'h1234_5678, 32'd0);
    check("mthi_const", {32'd0, hi}, {32'd0, 32'h1234_5678});
    run_op(1'b1, OpMtlo, 32'hCAFE_F00D, 32'd0);
    run_op(1'b0, OpMthi, 32'hDEAD_BEEF, 32'd0);
    check("mthi_nostart", {32'd0, hi}, {32'd0, 32'h1234_5678});

    // Start during RUN must be ignored
    model(1'b1, OpMult, 32'd12345, 32'hFFFF_0000, m_hi, m_lo, exp, lat);
    @(negedge clk);
    start = 1'b1; md_op = OpMult; rs_val = 32'd12345; rt_val = 32'hFFFF_0000;
    @(negedge clk);
    for (int i = 1; i <= MultCycles; i++) begin
      check("ign_busy", {63'd0, busy}, 64'd1);
      check("ign_hold", {hi, lo}, {m_hi, m_lo});
      if (i == 2) begin
        start = 1'b1; md_op = OpDiv; rs_val = 32'd100; rt_val = 32'd3;
      end else begin
        start = 1'b0; md_op = OpNone;
      end
      @(negedge clk);
    end
    check("ign_done", {63'd0, busy}, 64'd0);
    check("ign_result", {hi, lo}, exp);
    {m_hi, m_lo} = exp;
    @(negedge clk);
    check("ign_stay_idle", {63'd0, busy}, 64'd0);
    check("ign_stay_hilo", {hi, lo}, {m_hi, m_lo});

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; md_op = OpMult; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; md_op = OpNone;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1 check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (MultCycles + 1) begin
      @(negedge clk);
      check("post_rst_busy", {63'd0, busy}, 64'd0);
      check("post_rst_hilo", {hi, lo}, 64'd0);
    end
    run_op(1'b1, OpDiv, 32'd100, 32'd3);
    check("div_after_rst", {hi, lo}, {32'd1, 32'd33});

    // Accumulate path (no-op when the feature is not built)
    run_op(1'b1, OpMthi, 32'd0, 32'd0);
    run_op(1'b1, OpMtlo, 32'hFFFF_FFFF, 32'd0);
    run_op(1'b1, OpMaddu, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("maddu_const", {hi, lo}, {32'd1, 32'd0});
`else
    check("maddu_absent", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

    for (int n = 0; n < 40; n++) begin
      run_op(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), pick_operand(),
             pick_operand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
